// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types, constants and address-check helper for the
//               cpu_mem_responder memory-side block.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int WORD_W = 32;

  // Responder operating phases
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Which access caused the sticky fault
  localparam logic FC_FETCH = 1'b0;
  localparam logic FC_STORE = 1'b1;

  // A byte address is usable when it is word aligned and its word index
  // falls inside a memory of 'words' entries.
  function automatic logic word_ok(input logic [WORD_W-1:0] addr,
                                   input int unsigned      words);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[WORD_W-1:2]} < words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_responder_if
// Description : Load stream, core fetch/data port and status signals of the
//               memory responder. 'slave' is the responder side, 'master' is
//               the loader/core side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_mem_responder_if;
  import mem_pkg::*;

  logic              ld_valid;
  logic              ld_ready;
  logic [WORD_W-1:0] ld_data;
  logic              ld_last;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] addr_data;
  logic [WORD_W-1:0] write_data;
  logic              we;
  logic [WORD_W-1:0] read_data;
  logic              cpu_reset;
  logic              fault;
  logic [WORD_W-1:0] fault_addr;
  logic [15:0]       load_count;

  modport slave (
    input  ld_valid, ld_data, ld_last, pc, addr_data, write_data, we,
    output ld_ready, instr, read_data, cpu_reset, fault, fault_addr, load_count
  );

  modport master (
    output ld_valid, ld_data, ld_last, pc, addr_data, write_data, we,
    input  ld_ready, instr, read_data, cpu_reset, fault, fault_addr, load_count
  );

endinterface
`default_nettype wire

// File: rtl/word_ram.sv
`default_nettype none
// ============================================================================
// Module      : word_ram
// Description : Word-wide RAM with one synchronous write port and one
//               asynchronous read port. DEPTH must be a power of two >= 2.
// Revision    : 1.0 - initial release
// ============================================================================
module word_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  wire logic                     clk,
  input  wire logic                     we_i,
  input  wire logic [$clog2(DEPTH)-1:0] waddr_i,
  input  wire logic [WIDTH-1:0]         wdata_i,
  input  wire logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic      [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: contents carry no reset; callers mask or clear them.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_responder
// Description : Memory-side responder for the single-cycle core. Clears data
//               memory after reset, accepts a program over a valid/ready
//               stream, then releases the core and serves fetches, loads and
//               stores. Bad fetches/stores park the core in a sticky fault.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_mem_responder
  import mem_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  wire logic         clk,
  input  wire logic         reset,
  cpu_mem_responder_if.slave bus
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [15:0]    LC_LAST  = 16'(IMEM_WORDS - 1);
  localparam logic [15:0]    LC_MAX   = 16'(IMEM_WORDS);
  localparam logic [DAW-1:0] CLR_LAST = DAW'(DMEM_WORDS - 1);

  state_e             state_q, state_d;
  logic [DAW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [15:0]        load_count_q, load_count_d;
  logic               fault_q, fault_d;
  logic [WORD_W-1:0]  fault_addr_q, fault_addr_d;
  logic               cpu_reset_q;

  logic               is_run;
  logic               ld_fire;
  logic [IAW-1:0]     fetch_idx;
  logic [DAW-1:0]     data_idx;
  logic               fetch_ok;
  logic               fetch_loaded;
  logic               data_ok;
  logic               fetch_bad;
  logic               store_bad;
  logic               fault_cause;

  logic               imem_we;
  logic [WORD_W-1:0]  imem_rdata;
  logic               dmem_we;
  logic [DAW-1:0]     dmem_waddr;
  logic [WORD_W-1:0]  dmem_wdata;
  logic [WORD_W-1:0]  dmem_rdata;

  assign is_run       = (state_q == ST_RUN);
  assign ld_fire      = (state_q == ST_LOAD) && bus.ld_valid;
  assign fetch_idx    = bus.pc[IAW+1:2];
  assign data_idx     = bus.addr_data[DAW+1:2];
  assign fetch_ok     = word_ok(bus.pc, IMEM_WORDS);
  assign fetch_loaded = fetch_ok && (16'(fetch_idx) < load_count_q);
  assign data_ok      = word_ok(bus.addr_data, DMEM_WORDS);
  assign fetch_bad    = is_run && !fetch_ok;
  assign store_bad    = is_run && bus.we && !data_ok;

  // Phase sequencing, memory write steering and fault capture.
  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    load_count_d = load_count_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    fault_cause  = FC_FETCH;
    imem_we      = 1'b0;
    dmem_we      = 1'b0;
    dmem_waddr   = clr_ptr_q;
    dmem_wdata   = '0;

    case (state_q)
      ST_CLEAR: begin
        dmem_we   = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == CLR_LAST) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ld_fire) begin
          imem_we = 1'b1;
          if (load_count_q != LC_MAX) begin
            load_count_d = load_count_q + 16'd1;
          end
          // The image ends on ld_last or when the last slot is filled.
          if (bus.ld_last || (load_count_q == LC_LAST)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (fetch_bad || store_bad) begin
          // Fetch faults win; the offending store is never written.
          fault_cause  = fetch_bad ? FC_FETCH : FC_STORE;
          state_d      = ST_FAULT;
          fault_d      = 1'b1;
          fault_addr_d = (fault_cause == FC_FETCH) ? bus.pc : bus.addr_data;
        end else if (bus.we) begin
          dmem_we    = 1'b1;
          dmem_waddr = data_idx;
          dmem_wdata = bus.write_data;
        end
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // State and status registers; core reset follows the next state so it
  // changes on the same edge as the phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= '0;
      load_count_q <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      cpu_reset_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      load_count_q <= load_count_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      cpu_reset_q  <= (state_d != ST_RUN);
    end
  end

  word_ram #(.DEPTH(IMEM_WORDS), .WIDTH(WORD_W)) u_imem (
    .clk     (clk),
    .we_i    (imem_we),
    .waddr_i (load_count_q[IAW-1:0]),
    .wdata_i (bus.ld_data),
    .raddr_i (fetch_idx),
    .rdata_o (imem_rdata)
  );

  word_ram #(.DEPTH(DMEM_WORDS), .WIDTH(WORD_W)) u_dmem (
    .clk     (clk),
    .we_i    (dmem_we),
    .waddr_i (dmem_waddr),
    .wdata_i (dmem_wdata),
    .raddr_i (data_idx),
    .rdata_o (dmem_rdata)
  );

  // Unloaded slots read as nop so stale images from before a reset stay hidden.
  assign bus.instr      = (is_run && fetch_loaded) ? imem_rdata : '0;
  assign bus.read_data  = (is_run && data_ok) ? dmem_rdata : '0;
  assign bus.ld_ready   = (state_q == ST_LOAD);
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.fault      = fault_q;
  assign bus.fault_addr = fault_addr_q;
  assign bus.load_count = load_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem_responder
// Description : Scoreboard bench for cpu_mem_responder with a behavioural
//               model of the memories and load/run/fault phases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_responder;

  localparam int WORDS   = 256;
  localparam int M_CLEAR = 0;
  localparam int M_LOAD  = 1;
  localparam int M_RUN   = 2;
  localparam int M_FAULT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_mem_responder_if bus();

  cpu_mem_responder #(.IMEM_WORDS(WORDS), .DMEM_WORDS(WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rdata;
    logic [31:0] faddr;
    logic        ldr;
    logic        cres;
    logic        flt;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int          m_mode;
  int          m_clr_left;
  int          m_cnt;
  logic        m_fault;
  logic [31:0] m_faddr;
  logic [31:0] m_imem [WORDS];
  logic [31:0] m_dmem [WORDS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each cycle's expected outputs are compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("instr",      bus.instr,              e.instr);
      chk("read_data",  bus.read_data,          e.rdata);
      chk("fault_addr", bus.fault_addr,         e.faddr);
      chk("ld_ready",   {31'd0, bus.ld_ready},  {31'd0, e.ldr});
      chk("cpu_reset",  {31'd0, bus.cpu_reset}, {31'd0, e.cres});
      chk("fault",      {31'd0, bus.fault},     {31'd0, e.flt});
      chk("load_count", {16'd0, bus.load_count}, {16'd0, e.cnt});
    end
  end

  function automatic bit addr_good(input logic [31:0] a);
    return (a % 4 == 0) && ((a / 4) < WORDS);
  endfunction

  function automatic exp_t predict();
    exp_t e;
    e.instr = 32'd0;
    e.rdata = 32'd0;
    if (m_mode == M_RUN && bus.pc % 4 == 0 && (bus.pc / 4) < 32'(m_cnt))
      e.instr = m_imem[bus.pc / 4];
    if (m_mode == M_RUN && addr_good(bus.addr_data))
      e.rdata = m_dmem[bus.addr_data / 4];
    e.faddr = m_faddr;
    e.ldr   = (m_mode == M_LOAD);
    e.cres  = (m_mode != M_RUN);
    e.flt   = m_fault;
    e.cnt   = 16'(m_cnt);
    return e;
  endfunction

  task automatic model_reset();
    m_mode     = M_CLEAR;
    m_clr_left = WORDS;
    m_cnt      = 0;
    m_fault    = 1'b0;
    m_faddr    = 32'd0;
    for (int i = 0; i < WORDS; i++) m_dmem[i] = 32'd0;
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    case (m_mode)
      M_CLEAR: begin
        m_clr_left--;
        if (m_clr_left == 0) m_mode = M_LOAD;
      end
      M_LOAD: begin
        if (bus.ld_valid) begin
          m_imem[m_cnt] = bus.ld_data;
          m_cnt++;
          if (bus.ld_last || m_cnt == WORDS) m_mode = M_RUN;
        end
      end
      M_RUN: begin
        if (!addr_good(bus.pc)) begin
          m_mode = M_FAULT; m_fault = 1'b1; m_faddr = bus.pc;
        end else if (bus.we && !addr_good(bus.addr_data)) begin
          m_mode = M_FAULT; m_fault = 1'b1; m_faddr = bus.addr_data;
        end else if (bus.we) begin
          m_dmem[bus.addr_data / 4] = bus.write_data;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    exp_q.push_back(predict());
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    bit done;
    done = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    for (int k = 0; k < 1000 && !done; k++) begin
      done = (m_mode == M_LOAD);
      tick();
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_timeout: got no handshake expected handshake");
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic run_random(input int n);
    for (int k = 0; k < n; k++) begin
      bus.pc         = 4 * $urandom_range(0, 7);
      bus.we         = 1'($urandom_range(0, 1));
      bus.addr_data  = 4 * $urandom_range(0, 15);
      bus.write_data = $urandom;
      bus.ld_valid   = 1'($urandom_range(0, 1));
      bus.ld_data    = $urandom;
      tick();
    end
    bus.pc = 0; bus.we = 1'b0; bus.addr_data = 0; bus.ld_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_data = 0; bus.ld_last = 1'b0;
    bus.pc = 0; bus.addr_data = 0; bus.write_data = 0; bus.we = 1'b0;
    @(posedge clk); #1;

    // Phase 1: clear then three-word image with ld_valid held through CLEAR
    do_reset();
    load_word(32'h03A03002, 1'b0);
    load_word(32'h02833001, 1'b0);
    load_word($urandom, 1'b1);
    tick();
    bus.pc = 4;  tick();
    bus.pc = 12; tick();
    bus.pc = 0;
    bus.we = 1'b1; bus.addr_data = 8; bus.write_data = 32'hDEADBEEF; tick();
    bus.we = 1'b0; tick();
    run_random(150);
    bus.addr_data = 8; bus.we = 1'b1; bus.write_data = 32'hDEADBEEF; tick();
    bus.we = 1'b0;
    bus.pc = 2; tick();
    bus.pc = 0; tick(); tick();

    // Phase 2: reset mid-LOAD, reload, stale data masked and dmem re-cleared
    do_reset();
    for (int i = 0; i < 5; i++) load_word($urandom, 1'b0);
    tick();
    do_reset();
    tick();
    for (int i = 0; i < 2; i++) load_word($urandom, 1'b0);
    load_word($urandom, 1'b1);
    bus.addr_data = 8; tick();
    bus.pc = 16; tick();
    bus.pc = 12; tick();
    bus.pc = 0;
    bus.we = 1'b1; bus.addr_data = 32'h400; bus.write_data = 32'h12345678; tick();
    bus.we = 1'b0; bus.addr_data = 0; tick();
    bus.pc = 6; tick();
    bus.pc = 0; tick();

    // Phase 3: full image without ld_last stops at the last slot
    do_reset();
    for (int i = 0; i < WORDS; i++) load_word($urandom, 1'b0);
    bus.ld_valid = 1'b1; bus.ld_data = $urandom; tick();
    bus.ld_valid = 1'b0; tick();
    for (int i = 0; i < 40; i++) begin
      bus.pc = 4 * $urandom_range(0, WORDS - 1);
      tick();
    end
    bus.pc = 32'h400; tick();
    bus.pc = 0; tick();

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
